sram_access_arbiter: RTL
========================

// Module: sram_access_arbiter
// PURPOSE
//  Shares the single external SRAM port between the VGA scan-out reader (latency-critical, read-only)
//  and the text renderer (read/write). Sits between both requesters and the SRAM pin driver.
//  Serialises one transaction at a time, sequences the fixed-length SRAM access cycle and routes
//  each response back to its owner. VGA normally wins; a starvation guard bounds renderer wait.
// PARAMETERS
//  ADDR_W         20  SRAM word address width
//  DATA_W         32  SRAM data width
//  ACCESS_CYCLES  2   cycles the SRAM bus is held per access (legal range 2..15)
//  STARVE_LIMIT   8   consecutive VGA wins while renderer waits before renderer is forced (1..255)
// PORTS
//  clk            in   1       system clock; all state changes on rising edge
//  rst            in   1       asynchronous, active-low reset
//  vga_req_valid  in   1       VGA read request pending
//  vga_req_addr   in   ADDR_W  VGA read address
//  vga_req_ready  out  1       1-cycle accept pulse for the VGA request
//  vga_resp_valid out  1       1-cycle pulse: vga_resp_data valid
//  vga_resp_data  out  DATA_W  VGA read data
//  rnd_req_valid  in   1       renderer request pending
//  rnd_req_write  in   1       1 = write, 0 = read
//  rnd_req_addr   in   ADDR_W  renderer address
//  rnd_req_wdata  in   DATA_W  renderer write data
//  rnd_req_ready  out  1       1-cycle accept pulse for the renderer request
//  rnd_resp_valid out  1       1-cycle pulse: read data valid, or write complete
//  rnd_resp_data  out  DATA_W  renderer read data (0 on write completion)
//  mem_addr       out  ADDR_W  SRAM address
//  mem_wdata      out  DATA_W  SRAM write data
//  mem_drive      out  1       enables the pin driver's tristate output buffer
//  mem_we         out  1       SRAM write strobe, active-high
//  mem_oe         out  1       SRAM output enable, active-high
//  mem_rdata      in   DATA_W  SRAM read data, sampled synchronously
// BEHAVIOUR
//  - Reset: every output is 0, FSM is IDLE, starve_cnt is 0, the latched transaction is cleared.
//    Reset asserted mid-access aborts the access. No response is issued for the aborted access.
//  - FSM states: IDLE, ACCESS.
//  - IDLE with no valid request: stay in IDLE; all mem_* outputs are 0.
//  - IDLE with a valid request: choose a winner. Renderer wins if starve_cnt == STARVE_LIMIT, or
//    if only the renderer is valid. Otherwise VGA wins.
//  - On a win: pulse the winner's *_ready combinationally in that IDLE cycle (T). Latch the owner,
//    address, write flag and write data. Load acc_cnt = 0 and go to ACCESS.
//  - ACCESS spans cycles T+1 .. T+ACCESS_CYCLES. mem_addr holds the latched address throughout.
//    - Read: mem_oe = 1 for all ACCESS cycles.
//    - Write: mem_drive = 1 for all ACCESS cycles. mem_we = 1 on every ACCESS cycle except the
//      last, giving address/data hold on the trailing edge.
//  - On the last ACCESS cycle: register mem_rdata (reads) or 0 (writes) into the owner's resp_data
//    and return to IDLE.
//  - The owner's resp_valid pulses at T+ACCESS_CYCLES+1, coinciding with the next IDLE cycle.
//  - Back-to-back: that same IDLE cycle may accept a new request. Peak rate is one access per
//    ACCESS_CYCLES+1 cycles.
//  - starve_cnt: increments (saturating at STARVE_LIMIT) when VGA wins while rnd_req_valid = 1.
//    Clears to 0 when the renderer wins. Unchanged otherwise.
//  - Requesters must hold valid and payload stable until ready. Dropping valid before ready is
//    legal; the request is simply not taken.
//  - At most one *_ready and one *_resp_valid are high in any cycle. resp_data holds its value
//    between pulses.
//  - Unused mem_wdata drives 0 when mem_drive = 0.
// CONFIGURATION
//  SRAM_ARB_STATS_EN defined:
//    - Adds outputs stat_vga_grants[15:0], stat_rnd_grants[15:0] and stat_forced[15:0].
//    - Each counts accepted requests, wraps modulo 2^16 and resets to 0.
//    - stat_forced counts renderer wins caused by starve_cnt == STARVE_LIMIT.
//  SRAM_ARB_STATS_EN undefined: the counters and ports are absent. All other behaviour is identical.
// TESTING
//  1. VGA read only, addr 0x00010, mem_rdata 0xDEADBEEF
//     -> vga_req_ready at T, mem_oe at T+1..T+2, vga_resp_valid at T+3 with data 0xDEADBEEF.
//  2. Renderer write addr 0x00FFF, data 0x12345678
//     -> mem_drive at T+1..T+2, mem_we at T+1 only, rnd_resp_valid at T+3 with data 0.
//  3. Both valid continuously, STARVE_LIMIT=8
//     -> 8 VGA grants, then 1 renderer grant; the pattern repeats. Consecutive grants are spaced
//        3 cycles apart.
//  4. Renderer valid alone after starvation counting -> immediate grant, starve_cnt returns to 0.
//  5. rst low at T+1 of a read -> all outputs 0 immediately, no resp_valid.
//     After rst high, the next request is served normally.
//  6. With SRAM_ARB_STATS_EN, scenario 3 for 27 grants -> stat_vga_grants=24, stat_rnd_grants=3,
//     stat_forced=3.

Source files
------------

// File: rtl/sram_access_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : sram_access_arbiter
// Description : Shares one SRAM port between the VGA reader and the text
//               renderer. Optional statistics: define SRAM_ARB_STATS_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module sram_access_arbiter #(
    parameter int ADDR_W        = 20,
    parameter int DATA_W        = 32,
    parameter int ACCESS_CYCLES = 2,
    parameter int STARVE_LIMIT  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              vga_req_valid,
    input  logic [ADDR_W-1:0] vga_req_addr,
    output logic              vga_req_ready,
    output logic              vga_resp_valid,
    output logic [DATA_W-1:0] vga_resp_data,
    input  logic              rnd_req_valid,
    input  logic              rnd_req_write,
    input  logic [ADDR_W-1:0] rnd_req_addr,
    input  logic [DATA_W-1:0] rnd_req_wdata,
    output logic              rnd_req_ready,
    output logic              rnd_resp_valid,
    output logic [DATA_W-1:0] rnd_resp_data,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_drive,
    output logic              mem_we,
    output logic              mem_oe,
    input  logic [DATA_W-1:0] mem_rdata
`ifdef SRAM_ARB_STATS_EN
    ,
    output logic [15:0]       stat_vga_grants,
    output logic [15:0]       stat_rnd_grants,
    output logic [15:0]       stat_forced
`endif
);

    typedef enum logic [0:0] {
        S_IDLE   = 1'b0,
        S_ACCESS = 1'b1
    } state_t;

    localparam logic [3:0] c_LAST_ACC     = 4'(ACCESS_CYCLES - 1);
    localparam logic [7:0] c_STARVE_LIMIT = 8'(STARVE_LIMIT);

    state_t              r_state;
    state_t              w_nextState;
    logic [3:0]          r_accCnt;
    logic                r_ownerRnd;
    logic                r_write;
    logic [ADDR_W-1:0]   r_addr;
    logic [DATA_W-1:0]   r_wdata;
    logic [7:0]          r_starveCnt;
    logic                r_vgaRespValid;
    logic                r_rndRespValid;
    logic [DATA_W-1:0]   r_vgaRespData;
    logic [DATA_W-1:0]   r_rndRespData;

    logic                w_inAccess;
    logic                w_lastAcc;
    logic                w_starved;
    logic                w_rndWin;
    logic                w_vgaWin;
    logic                w_grant;

    // Grants are gated by rst so every output reads 0 while reset is held.
    always_comb begin
        w_inAccess  = (r_state == S_ACCESS);
        w_lastAcc   = w_inAccess && (r_accCnt == c_LAST_ACC);
        w_starved   = (r_starveCnt == c_STARVE_LIMIT);
        w_rndWin    = rst && (r_state == S_IDLE) && rnd_req_valid
                      && (w_starved || !vga_req_valid);
        w_vgaWin    = rst && (r_state == S_IDLE) && vga_req_valid && !w_rndWin;
        w_grant     = w_rndWin || w_vgaWin;
        w_nextState = r_state;
        case (r_state)
            S_IDLE:   if (w_grant)   w_nextState = S_ACCESS;
            S_ACCESS: if (w_lastAcc) w_nextState = S_IDLE;
            default:                 w_nextState = S_IDLE;
        endcase

        vga_req_ready = w_vgaWin;
        rnd_req_ready = w_rndWin;
        mem_addr      = w_inAccess ? r_addr : '0;
        mem_oe        = w_inAccess && !r_write;
        mem_drive     = w_inAccess && r_write;
        // Dropping the strobe on the final cycle keeps address/data held past its trailing edge.
        mem_we        = w_inAccess && r_write && !w_lastAcc;
        mem_wdata     = (w_inAccess && r_write) ? r_wdata : '0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_accCnt       <= '0;
            r_ownerRnd     <= 1'b0;
            r_write        <= 1'b0;
            r_addr         <= '0;
            r_wdata        <= '0;
            r_starveCnt    <= '0;
            r_vgaRespValid <= 1'b0;
            r_rndRespValid <= 1'b0;
            r_vgaRespData  <= '0;
            r_rndRespData  <= '0;
        end else begin
            r_vgaRespValid <= 1'b0;
            r_rndRespValid <= 1'b0;

            if (w_grant) begin
                r_ownerRnd <= w_rndWin;
                r_write    <= w_rndWin && rnd_req_write;
                r_addr     <= w_rndWin ? rnd_req_addr : vga_req_addr;
                r_wdata    <= (w_rndWin && rnd_req_write) ? rnd_req_wdata : '0;
                r_accCnt   <= '0;
            end else if (w_inAccess) begin
                r_accCnt   <= r_accCnt + 4'd1;
            end

            if (w_lastAcc) begin
                if (r_ownerRnd) begin
                    r_rndRespValid <= 1'b1;
                    r_rndRespData  <= r_write ? '0 : mem_rdata;
                end else begin
                    r_vgaRespValid <= 1'b1;
                    r_vgaRespData  <= mem_rdata;
                end
            end

            if (w_rndWin) begin
                r_starveCnt <= '0;
            end else if (w_vgaWin && rnd_req_valid && !w_starved) begin
                r_starveCnt <= r_starveCnt + 8'd1;
            end
        end
    end

    assign vga_resp_valid = r_vgaRespValid;
    assign vga_resp_data  = r_vgaRespData;
    assign rnd_resp_valid = r_rndRespValid;
    assign rnd_resp_data  = r_rndRespData;

`ifdef SRAM_ARB_STATS_EN
    logic [15:0] r_statVga;
    logic [15:0] r_statRnd;
    logic [15:0] r_statForced;

    // A forced win is one the renderer would have lost had the guard not fired.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_statVga    <= '0;
            r_statRnd    <= '0;
            r_statForced <= '0;
        end else begin
            if (w_vgaWin) r_statVga <= r_statVga + 16'd1;
            if (w_rndWin) r_statRnd <= r_statRnd + 16'd1;
            if (w_rndWin && w_starved && vga_req_valid) r_statForced <= r_statForced + 16'd1;
        end
    end

    assign stat_vga_grants = r_statVga;
    assign stat_rnd_grants = r_statRnd;
    assign stat_forced     = r_statForced;
`endif

endmodule
`default_nettype wire
